// File: rtl/ma_frame_scheduler_pkg.sv
// Shared types for the frame scheduler: FSM encoding and select-width helper.
package ma_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int MAX_CH    = 16;
    localparam int MAX_SEL_W = 4;

    // Context select width; a single channel still needs a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ma_issue_delay.sv
// LAT-deep delay line carrying {ce, sel} so results land in the lane they were issued for.
module ma_issue_delay
    import ma_frame_scheduler_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             ce_in,
    input  logic [SEL_W-1:0] sel_in,
    output logic             ce_out,
    output logic [SEL_W-1:0] sel_out
);

    logic [LAT:1]            vld_pipe;
    logic [LAT:1][SEL_W-1:0] sel_pipe;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_pipe <= '0;
            sel_pipe <= '0;
        end else begin
            vld_pipe[1] <= ce_in;
            sel_pipe[1] <= sel_in;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sel_pipe[i] <= sel_pipe[i-1];
            end
        end
    end

    assign ce_out  = vld_pipe[LAT];
    assign sel_out = sel_pipe[LAT];

endmodule

// File: rtl/ma_frame_scheduler.sv
// Time-multiplexes NUM_CH channels through one context-banked moving-average datapath
// once per DECIM-cycle tick and reassembles the filtered frame.
module ma_frame_scheduler
    import ma_frame_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DECIM      = 100,
    parameter int LAT        = 1
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic                                 en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         din,
    output logic                                 ma_ce,
    output logic [sel_width(NUM_CH)-1:0]         ma_sel,
    output logic [DATA_WIDTH-1:0]                ma_din,
    input  logic [DATA_WIDTH-1:0]                ma_dout,
    output logic [NUM_CH*DATA_WIDTH-1:0]         dout,
    output logic                                 dout_valid,
    output logic                                 overrun
);

    localparam int SEL_W = sel_width(NUM_CH);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] frame_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    frame_t           din_v, snap, dout_r;
    logic [SEL_W-1:0] idx, sel_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic             last_issue;
    logic             dl_ce;
    logic [SEL_W-1:0] dl_sel;

    assign din_v      = din;
    assign tick       = en && (tick_cnt == CNT_W'(DECIM - 1));
    assign last_issue = (idx == SEL_W'(NUM_CH - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            tick_cnt <= '0;
        else if (!en || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (tick) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_ISSUE;
            ST_ISSUE:   if (last_issue) state_nxt = ST_DRAIN;
            // Leave DRAIN in the cycle the final channel's result is written.
            ST_DRAIN:   if (dl_ce && dl_sel == SEL_W'(NUM_CH - 1)) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Issue-port values are held outside ISSUE so the datapath bus stays quiet.
    assign ma_ce      = (state == ST_ISSUE);
    assign ma_sel     = ma_ce ? idx       : sel_q;
    assign ma_din     = ma_ce ? snap[idx] : din_q;
    assign dout_valid = (state == ST_DONE);
    assign dout       = dout_r;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            snap    <= '0;
            idx     <= '0;
            sel_q   <= '0;
            din_q   <= '0;
            overrun <= 1'b0;
            dout_r  <= '0;
        end else begin
            if (state == ST_CAPTURE)
                snap <= din_v;
            if (state == ST_ISSUE)
                idx <= last_issue ? '0 : idx + SEL_W'(1);
            sel_q <= ma_sel;
            din_q <= ma_din;
            if (tick && state != ST_IDLE)
                overrun <= 1'b1;
            for (int k = 0; k < NUM_CH; k++)
                if (dl_ce && dl_sel == SEL_W'(k))
                    dout_r[k] <= ma_dout;
        end
    end

    ma_issue_delay #(
        .LAT   (LAT),
        .SEL_W (SEL_W)
    ) u_issue_delay (
        .clk     (clk),
        .aresetn (aresetn),
        .ce_in   (ma_ce),
        .sel_in  (ma_sel),
        .ce_out  (dl_ce),
        .sel_out (dl_sel)
    );

endmodule

// File: doc/ma_frame_scheduler.md
MA_FRAME_SCHEDULER -- requirements
Module: ma_frame_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter NUM_CH, default 4, number of input channels sharing one context-banked moving-average datapath (range 1..16).
REQ-003 Parameter DECIM, default 100, sample-tick period in clk cycles (range NUM_CH+LAT+4..65535).
REQ-004 Parameter LAT, default 1, clk cycles from a datapath ma_ce pulse to its valid ma_dout (range 1..8).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 aresetn  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  tick enable; low holds the tick counter at 0.
REQ-008 din  input  NUM_CH*DATA_WIDTH  packed channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 ma_ce  output  1  one-clock issue strobe to the datapath.
REQ-010 ma_sel  output  clog2(NUM_CH) (minimum 1)  datapath context/channel select, valid when ma_ce=1.
REQ-011 ma_din  output  DATA_WIDTH  sample issued to the datapath, valid when ma_ce=1.
REQ-012 ma_dout  input  DATA_WIDTH  datapath result, sampled exactly LAT clocks after the matching ma_ce.
REQ-013 dout  output  NUM_CH*DATA_WIDTH  packed filtered frame, same layout as din.
REQ-014 dout_valid  output  1  one-clock pulse when all NUM_CH dout lanes are updated.
REQ-015 overrun  output  1  sticky flag: a tick arrived while a frame was in flight.

Function
REQ-016 Tick counter SHALL count 0..DECIM-1 while en=1 and wrap; a tick SHALL be generated in the cycle the counter equals DECIM-1.
REQ-017 FSM states SHALL be IDLE, CAPTURE, ISSUE, DRAIN, DONE.
REQ-018 IDLE -> CAPTURE on tick; CAPTURE SHALL latch all of din into a snapshot register in one clock, then go to ISSUE.
REQ-019 ISSUE SHALL assert ma_ce for NUM_CH consecutive clocks with ma_sel=0,1,...,NUM_CH-1 and ma_din=snapshot lane ma_sel, then go to DRAIN.
REQ-020 ma_ce SHALL be 0, and ma_sel/ma_din SHALL hold their previous values, in every state other than ISSUE.
REQ-021 A LAT-deep shift register SHALL carry {ce, sel}; when its output ce=1, ma_dout SHALL be written to dout lane sel, and other lanes SHALL hold.
REQ-022 DRAIN SHALL last until the last channel's result is written (exactly LAT clocks after the final issue), then go to DONE.
REQ-023 DONE SHALL assert dout_valid for one clock and return to IDLE; tick-to-dout_valid latency SHALL be NUM_CH+LAT+2 clocks.
REQ-024 A tick in any state other than IDLE SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-025 en falling mid-frame SHALL NOT abort the frame; the in-flight frame SHALL complete with dout_valid.
REQ-026 The tick counter SHALL reset to 0 in the cycle en is sampled low.
REQ-027 No arithmetic on sample data; lanes SHALL pass bit-exact, including sign.

Reset
REQ-028 While aresetn=0: FSM=IDLE, tick counter=0, ma_ce=0, ma_sel=0, ma_din=0, dout=0, dout_valid=0, overrun=0, snapshot=0, delay line cleared.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no dout_valid SHALL follow reset release until a new tick.
REQ-030 Reset release SHALL be synchronously deasserted externally; the first tick SHALL occur DECIM clocks after release with en=1.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the clog2-based select-width constant.
REQ-032 The LAT-deep {ce, sel} delay line SHALL be a sub-module, ma_issue_delay.

Verification
REQ-033 NUM_CH=4, LAT=1, DECIM=100, din lanes {15,0,-15,10}, datapath modelled as pass-through -> dout={15,0,-15,10}, dout_valid 7 clocks after tick.
REQ-034 Datapath model returns sel*100 -> dout lanes {0,100,200,300}; no lane written out of order.
REQ-035 DECIM forced to 6, NUM_CH=4, LAT=1 -> second tick drops, overrun=1 and stays 1; dout_valid count equals accepted ticks.
REQ-036 en dropped during ISSUE -> frame completes with dout_valid; no further ticks while en=0; after en returns high, first tick 100 clocks later.
REQ-037 aresetn pulsed low during DRAIN -> all outputs 0 immediately, no dout_valid until next tick.
REQ-038 LAT=3, din lanes all -32768 -> dout lanes all -32768, latency 9 clocks from tick.
